// File: rtl/alu_exec_stage_if.sv
// Issue/result handshake bundle for alu_exec_stage.
// master is the issuing/consuming side, slave is the execute stage.
interface alu_exec_stage_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [5:0]       out_flags;
    logic             out_illegal;

    modport master (
        output in_valid, in_funct, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag,
        input  out_flags, out_illegal
    );

    modport slave (
        input  in_valid, in_funct, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag,
        output out_flags, out_illegal
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: in-order issue queue feeding alu_64, registered result slot
// and a sticky flag register for later branch resolution.
module alu_exec_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_exec_stage_if.slave        bus,
    output logic [2:0]             alu_funct,
    output logic [63:0]            alu_a,
    output logic [63:0]            alu_b,
    input  logic [63:0]            alu_result,
    input  logic                   alu_overflow,
    input  logic                   alu_negative,
    input  logic                   alu_zero,
    input  logic                   alu_equal,
    input  logic                   alu_greater,
    input  logic                   alu_less,
    output logic [5:0]             flags,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]       funct;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt_q;
    logic             empty;
    logic             push;
    logic             cap;
    logic             illegal;
    logic [5:0]       alu_flags;
    logic             out_valid_q;
    logic [63:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [5:0]       out_flags_q;
    logic             out_illegal_q;
    logic [5:0]       flags_q;

    assign head      = mem[rptr];
    assign empty     = (cnt_q == '0);
    assign illegal   = (head.funct == 3'd7);
    assign alu_flags = {alu_overflow, alu_negative, alu_zero,
                        alu_equal, alu_greater, alu_less};

    // in_ready sees only registered state, never out_ready
    assign bus.in_ready = !reset && (cnt_q != FULL);
    assign push = bus.in_valid && bus.in_ready;
    assign cap  = !empty && (!out_valid_q || bus.out_ready);

    always_comb begin
        alu_funct = 3'd0;
        alu_a     = 64'd0;
        alu_b     = 64'd0;
        if (!empty) begin
            alu_funct = head.funct;
            alu_a     = head.a;
            alu_b     = head.b;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{funct: bus.in_funct, a: bus.in_a,
                           b: bus.in_b, tag: bus.in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (cap) rptr <= rptr + 1'b1;
            case ({push, cap})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= 64'd0;
            out_tag_q     <= '0;
            out_flags_q   <= 6'd0;
            out_illegal_q <= 1'b0;
            flags_q       <= 6'd0;
        end else if (cap) begin
            out_valid_q <= 1'b1;
            out_tag_q   <= head.tag;
            // funct 7 ignores the ALU entirely and leaves the sticky flags
            if (illegal) begin
                out_result_q  <= 64'd0;
                out_flags_q   <= 6'd0;
                out_illegal_q <= 1'b1;
            end else begin
                out_result_q  <= alu_result;
                out_flags_q   <= alu_flags;
                out_illegal_q <= 1'b0;
                flags_q       <= alu_flags;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_flags   = out_flags_q;
    assign bus.out_illegal = out_illegal_q;
    assign flags           = flags_q;
    assign count           = cnt_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with a behavioural alu_64
// closing the loop on the ALU side.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alu_funct;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic        alu_negative;
    logic        alu_zero;
    logic        alu_equal;
    logic        alu_greater;
    logic        alu_less;
    logic [5:0]  flags;
    logic [2:0]  count;
    int          checks = 0;
    int          errors = 0;

    alu_exec_stage_if #(.TAG_W(5)) bus ();

    alu_exec_stage #(.DEPTH(4), .TAG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .alu_funct    (alu_funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_equal    (alu_equal),
        .alu_greater  (alu_greater),
        .alu_less     (alu_less),
        .flags        (flags),
        .count        (count)
    );

    always #5 clk = ~clk;

    // alu_64 stand-in; funct 7 returns junk the stage must ignore
    always_comb begin
        alu_result   = 64'hDEAD_BEEF;
        alu_overflow = 1'b0;
        unique case (alu_funct)
            3'd0: alu_result = alu_a;
            3'd1: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[63] == alu_b[63]) &&
                               (alu_result[63] != alu_a[63]);
            end
            3'd2: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[63] != alu_b[63]) &&
                               (alu_result[63] != alu_a[63]);
            end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: begin
                alu_result   = alu_a + 64'd1;
                alu_overflow = (alu_a == 64'h7FFF_FFFF_FFFF_FFFF);
            end
            default: alu_result = 64'hDEAD_BEEF;
        endcase
        alu_negative = alu_result[63];
        alu_zero     = (alu_result == 64'd0);
        alu_equal    = (alu_a == alu_b);
        alu_greater  = ($signed(alu_a) > $signed(alu_b));
        alu_less     = ($signed(alu_a) < $signed(alu_b));
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic push1(input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_funct = f;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout tag=%0d: in_ready=%b, required 1",
                     t, bus.in_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, count, flags, bus.out_result, bus.out_tag,
             bus.out_flags, bus.out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d flags=%b res=%h",
                     bus.out_valid, count, flags, bus.out_result);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b, required 1",
                     bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_sum();
        bus.out_ready = 1'b1;
        push1(3'd1, 64'd12, 64'd25, 5'd1);
        checks++;
        if (bus.out_valid !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL sum_latency: valid=%b count=%0d, required 0/1",
                     bus.out_valid, count);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd37 ||
            bus.out_flags !== 6'b000001 || flags !== 6'b000001 ||
            bus.out_tag !== 5'd1 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL sum: v=%b res=%0d of=%b fl=%b tag=%0d, required 1/37/000001/000001/1",
                     bus.out_valid, bus.out_result, bus.out_flags, flags,
                     bus.out_tag);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sum_drain: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_sub();
        push1(3'd2, 64'd12, 64'd25, 5'd2);
        push1(3'd2, 64'd54, 64'd54, 5'd3);
        checks++;
        if (bus.out_valid !== 1'b1 ||
            bus.out_result !== 64'hFFFF_FFFF_FFFF_FFF3 ||
            bus.out_flags !== 6'b010001 || bus.out_tag !== 5'd2) begin
            errors++;
            $display("FAIL sub_neg: res=%h of=%b tag=%0d, required -13/010001/2",
                     bus.out_result, bus.out_flags, bus.out_tag);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd0 ||
            bus.out_flags !== 6'b001100 || bus.out_tag !== 5'd3) begin
            errors++;
            $display("FAIL sub_zero: res=%h of=%b tag=%0d, required 0/001100/3",
                     bus.out_result, bus.out_flags, bus.out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        push1(3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 5'd4);
        @(negedge clk);
        checks++;
        if (bus.out_result !== 64'h8000_0000_0000_0002 ||
            bus.out_flags !== 6'b110010) begin
            errors++;
            $display("FAIL ovf_sum: res=%h of=%b, required 8000000000000002/110010",
                     bus.out_result, bus.out_flags);
        end
        push1(3'd2, 64'h8000_0000_0000_0000, 64'd3, 5'd5);
        @(negedge clk);
        checks++;
        if (bus.out_result !== 64'h7FFF_FFFF_FFFF_FFFD ||
            bus.out_flags !== 6'b100001) begin
            errors++;
            $display("FAIL ovf_sub: res=%h of=%b, required 7ffffffffffffffd/100001",
                     bus.out_result, bus.out_flags);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        push1(3'd6, 64'd2, 64'd0, 5'd7);
        push1(3'd7, 64'd5, 64'd5, 5'd8);
        checks++;
        if (bus.out_result !== 64'd3 || bus.out_flags !== 6'b000010 ||
            flags !== 6'b000010 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL inc: res=%h of=%b fl=%b ill=%b, required 3/000010/000010/0",
                     bus.out_result, bus.out_flags, flags, bus.out_illegal);
        end
        push1(3'd5, 64'd0, 64'd0, 5'd9);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd8 ||
            bus.out_illegal !== 1'b1 || bus.out_result !== 64'd0 ||
            bus.out_flags !== 6'b0 || flags !== 6'b000010) begin
            errors++;
            $display("FAIL illegal: tag=%0d ill=%b res=%h of=%b fl=%b, required 8/1/0/0/000010",
                     bus.out_tag, bus.out_illegal, bus.out_result,
                     bus.out_flags, flags);
        end
        @(negedge clk);
        checks++;
        if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFF ||
            bus.out_flags !== 6'b010100 || flags !== 6'b010100 ||
            bus.out_illegal !== 1'b0 || bus.out_tag !== 5'd9) begin
            errors++;
            $display("FAIL not: res=%h of=%b fl=%b ill=%b, required -1/010100/010100/0",
                     bus.out_result, bus.out_flags, flags, bus.out_illegal);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int exp;
        int cyc;
        logic took;
        bus.out_ready = 1'b0;
        for (int t = 1; t <= 5; t++)
            push1(3'd1, 64'(t), 64'd100, 5'(t));
        bus.in_valid = 1'b1;
        bus.in_funct = 3'd1;
        bus.in_a     = 64'd6;
        bus.in_b     = 64'd100;
        bus.in_tag   = 5'd6;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || count !== 3'd4 ||
                bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1 ||
                bus.out_result !== 64'd101) begin
                errors++;
                $display("FAIL bp_stall%0d: rdy=%b cnt=%0d v=%b tag=%0d res=%0d, required 0/4/1/1/101",
                         i, bus.in_ready, count, bus.out_valid,
                         bus.out_tag, bus.out_result);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        exp = 1;
        cyc = 0;
        while (exp <= 6 && cyc < 20) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(exp) ||
                bus.out_result !== 64'(exp + 100)) begin
                errors++;
                $display("FAIL bp_drain: v=%b tag=%0d res=%0d, required 1/%0d/%0d",
                         bus.out_valid, bus.out_tag, bus.out_result,
                         exp, exp + 100);
            end
            exp++;
            took = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (took) bus.in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: out_valid=%b in_valid=%b, required 0/0",
                     bus.out_valid, bus.in_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        push1(3'd1, 64'd5, 64'd3, 5'd10);
        push1(3'd1, 64'd1, 64'd1, 5'd11);
        push1(3'd1, 64'd1, 64'd1, 5'd12);
        push1(3'd1, 64'd1, 64'd1, 5'd13);
        checks++;
        if (count !== 3'd3 || bus.out_valid !== 1'b1 ||
            flags !== 6'b000010) begin
            errors++;
            $display("FAIL rst_pre: cnt=%0d v=%b fl=%b, required 3/1/000010",
                     count, bus.out_valid, flags);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || flags !== 6'd0 ||
            bus.out_result !== 64'd0 || bus.out_tag !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: cnt=%0d v=%b fl=%b res=%h, required 0/0/0/0",
                     count, bus.out_valid, flags, bus.out_result);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale%0d: out_valid=%b tag=%0d, required 0",
                         i, bus.out_valid, bus.out_tag);
            end
        end
        push1(3'd1, 64'd20, 64'd22, 5'd20);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd20 ||
            bus.out_result !== 64'd42) begin
            errors++;
            $display("FAIL rst_after: v=%b tag=%0d res=%0d, required 1/20/42",
                     bus.out_valid, bus.out_tag, bus.out_result);
        end
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_funct  = 3'd0;
        bus.in_a      = 64'd0;
        bus.in_b      = 64'd0;
        bus.in_tag    = 5'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sum();
        test_sub();
        test_overflow();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage wrapper that sits directly upstream of `alu_64` and consumes its results. It buffers issued ALU operations in a small in-order queue, drives the head entry onto the combinational `alu_64` inputs, and captures result plus status flags into a registered output slot with valid/ready handshakes on both sides. It also keeps a sticky architectural flag register for later branch logic.

## Interface
- `DEPTH`, 4: issue queue entries; power of two, at least 2.
- `TAG_W`, 5: width of the opaque tag carried with each operation.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an operation is offered.
- `in_ready`  out  1  queue can accept; `= !reset && count < DEPTH`.
- `in_funct`  in  3  0 LOAD, 1 SUM, 2 SUB, 3 AND, 4 XOR, 5 NOT, 6 INC, 7 illegal.
- `in_a`, `in_b`  in  64  signed operands.
- `in_tag`  in  TAG_W  returned unchanged with the result.
- `alu_funct`  out  3  to `alu_64.funct`.
- `alu_a`, `alu_b`  out  64  to `alu_64.a` and `alu_64.b`.
- `alu_result`  in  64  from `alu_64.result`.
- `alu_overflow`, `alu_negative`, `alu_zero`, `alu_equal`, `alu_greater`, `alu_less`  in  1 each  from `alu_64`.
- `out_valid`  out  1  output slot holds a result.
- `out_ready`  in  1  consumer accepts the output slot.
- `out_result`  out  64  captured result.
- `out_tag`  out  TAG_W  tag of the captured op.
- `out_flags`  out  6  `{overflow, negative, zero, equal, greater, less}`, bit 5 down to bit 0.
- `out_illegal`  out  1  captured op had funct 7.
- `flags`  out  6  sticky status register, same bit order as `out_flags`.
- `count`  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- **Queue.** Circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus `count`.
  - Push when `in_valid && in_ready`. The entry holds funct, a, b and tag.
- **ALU drive.** Combinational from the head entry. When the queue is empty, `alu_funct`, `alu_a` and `alu_b` are all 0.
- **Capture.** Condition is `cap = (count != 0) && (!out_valid || out_ready)`.
  - On `cap`, pop the head and load `out_result`, `out_flags` and `out_tag` from the ALU and the head entry. Set `out_valid = 1`.
  - If `out_valid && out_ready && !cap`, clear `out_valid`. The data outputs hold their last values.
- **Illegal funct (7).** The op is still queued and captured in order.
  - `out_result = 0`, `out_flags = 0`, `out_illegal = 1`.
  - `flags` is not updated. The value of `alu_64` is ignored.
- **Legal op.** `out_illegal = 0`, and `flags <= alu flags` on capture.
- **Simultaneous push and pop.** `count` is unchanged; both pointers advance.
- **Push when full.** Impossible, because `in_ready` is low.
- **Ordering.** Operations complete strictly in issue order. There is no reordering and no drop.

## Timing
- **Reset** (synchronous, wins over all other events in the same cycle):
  - `count = 0`, both pointers 0.
  - `out_valid = 0`, `out_result = 0`, `out_tag = 0`, `out_flags = 0`, `out_illegal = 0`, `flags = 0`.
  - `in_ready = 0` while `reset` is high; it becomes 1 in the first cycle after reset deasserts.
- **Reset mid-operation.** All queued and captured ops are discarded, with no output handshake for them.
- **Latency.** An op accepted at edge k, with the queue empty and the output slot free or draining, is captured at edge k+1. `out_valid` is high after edge k+1.
- **Throughput.** One op per cycle when `out_ready` is held at 1.
- **Capacity.** DEPTH+1 ops can be outstanding: DEPTH in the queue and 1 in the output slot.
- **`in_ready` timing.** It depends only on registered `count` and `reset`. There is no combinational path from `out_ready` to `in_ready`.
- **Output stability.** `out_*` are stable while `out_valid && !out_ready`.

## Test plan
- **SUM.** Issue SUM, a=12, b=25, with `out_ready=1`.
  - `out_valid` one edge after accept; `out_result=37`.
  - `out_flags=6'b000001` (less); `flags` is the same.
- **SUB negative, then zero.**
  - SUB 12-25 gives `out_result=-13` and `out_flags=6'b010001` (negative and less).
  - The next op, SUB 54-54, gives `out_result=0` and `out_flags=6'b001100` (zero and equal).
- **Signed overflow.**
  - SUM of 0x7FFF_FFFF_FFFF_FFFF and 3 gives `out_flags[5]=1`.
  - SUB of 0x8000_0000_0000_0000 and 3 gives `out_flags[5]=1`.
- **Backpressure (DEPTH=4).** Hold `out_ready=0` and offer 6 ops with tags 1..6.
  - Tags 1..5 are accepted, then `in_ready=0` and `count=4`; tag 6 stalls.
  - Raise `out_ready`: tags 1..6 emerge in order, one per cycle, with values stable during the stall.
- **Illegal funct.** Issue funct 7 between an INC of a=2 (result 3) and a NOT of a=0 (result -1).
  - The middle output has `out_illegal=1`, `out_result=0` and `out_flags=0`.
  - `flags` keeps the INC value.
- **Reset mid-stream.** With 3 ops queued and `out_valid=1`, assert `reset` for one cycle.
  - Next cycle: `count=0`, `out_valid=0`, `flags=0`.
  - No stale results appear afterwards.
